// File: rtl/mem_miss_ctrl.sv
// Miss controller: arbitrates IF fetches and MEM loads/stores onto one backing-memory port.
// Build with MEM_MISS_STATS_EN defined to get the saturating miss-cycle counters.
module mem_miss_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MEM_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            if_adv,
  input  logic            if_kill,
  output logic [XLEN-1:0] if_rdata,
  output logic            fi_miss,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  input  logic [3:0]      dm_be,
  input  logic            dm_adv,
  output logic [XLEN-1:0] dm_rdata,
  output logic            mi_miss,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [31:0]     stat_if_cyc,
  output logic [31:0]     stat_dm_cyc
);

  localparam int unsigned BE_W   = 4;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_D_REQ,
    S_D_WAIT,
    S_I_REQ,
    S_I_WAIT
  } state_e;

  state_e            state_q;
  logic              if_done_q;
  logic              dm_done_q;
  logic              kill_q;
  logic              mem_req_valid_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic              mem_we_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic [XLEN-1:0]   if_rdata_q;
  logic [XLEN-1:0]   dm_rdata_q;

  logic              resp_v;
  logic [XLEN-1:0]   resp_data;
  logic              if_kill_hit;
  logic              unused_addr_lsb;

  // Optional register stage on the memory response path.
  generate
    if (MEM_LAT == 0) begin : g_lat0
      assign resp_v    = mem_resp_valid;
      assign resp_data = mem_rdata;
    end else begin : g_lat1
      logic            resp_v_q;
      logic [XLEN-1:0] resp_data_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          resp_v_q    <= 1'b0;
          resp_data_q <= '0;
        end else begin
          resp_v_q    <= mem_resp_valid;
          resp_data_q <= mem_rdata;
        end
      end
      assign resp_v    = resp_v_q;
      assign resp_data = resp_data_q;
    end
  endgenerate

  assign if_kill_hit     = if_kill && ((state_q == S_I_REQ) || (state_q == S_I_WAIT));
  assign unused_addr_lsb = ^if_addr[1:0];

  // Single-outstanding arbiter; data wins because it belongs to the older instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      if_done_q       <= 1'b0;
      dm_done_q       <= 1'b0;
      kill_q          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_we_q        <= 1'b0;
      mem_wdata_q     <= '0;
      mem_be_q        <= '0;
      if_rdata_q      <= '0;
      dm_rdata_q      <= '0;
    end else begin
      if (if_adv || if_kill) begin
        if_done_q <= 1'b0;
      end
      if (dm_adv) begin
        dm_done_q <= 1'b0;
      end
      if (if_kill_hit) begin
        kill_q <= 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          if (dm_req && !dm_done_q) begin
            state_q         <= S_D_REQ;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= dm_addr;
            mem_we_q        <= dm_we;
            mem_wdata_q     <= dm_wdata;
            mem_be_q        <= dm_be;
          end else if (if_req && !if_done_q) begin
            state_q         <= S_I_REQ;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= {if_addr[XLEN-1:2], 2'b00};
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= '0;
            mem_be_q        <= BE_W'(4'hF);
          end
        end
        S_D_REQ: begin
          if (mem_req_ready) begin
            state_q         <= S_D_WAIT;
            mem_req_valid_q <= 1'b0;
          end
        end
        S_D_WAIT: begin
          if (resp_v) begin
            state_q    <= S_IDLE;
            dm_rdata_q <= resp_data;
            dm_done_q  <= 1'b1;
          end
        end
        S_I_REQ: begin
          if (mem_req_ready) begin
            state_q         <= S_I_WAIT;
            mem_req_valid_q <= 1'b0;
          end
        end
        S_I_WAIT: begin
          // A squashed fetch still drains the port but never reports done.
          if (resp_v) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
            if (!(kill_q || if_kill)) begin
              if_rdata_q <= resp_data;
              if_done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q         <= S_IDLE;
          mem_req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign fi_miss       = if_req && !if_done_q;
  assign mi_miss       = dm_req && !dm_done_q;
  assign if_rdata      = if_rdata_q;
  assign dm_rdata      = dm_rdata_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;

`ifdef MEM_MISS_STATS_EN
  logic [STAT_W-1:0] stat_if_q;
  logic [STAT_W-1:0] stat_dm_q;

  // Saturating miss-cycle counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_if_q <= '0;
      stat_dm_q <= '0;
    end else begin
      if (fi_miss && (stat_if_q != STAT_W'(32'hFFFF_FFFF))) begin
        stat_if_q <= stat_if_q + STAT_W'(1);
      end
      if (mi_miss && (stat_dm_q != STAT_W'(32'hFFFF_FFFF))) begin
        stat_dm_q <= stat_dm_q + STAT_W'(1);
      end
    end
  end

  assign stat_if_cyc = stat_if_q;
  assign stat_dm_cyc = stat_dm_q;
`else
  assign stat_if_cyc = '0;
  assign stat_dm_cyc = '0;
`endif

endmodule
